regbank_sb: RTL and testbench
=============================

// Module: regbank_sb
// PURPOSE
//  Parametrised multi-port register bank with an integrated scoreboard: NUM_RD combinational
//  read ports, two prioritised write ports, optional hardwired-zero register 0, optional
//  write->read bypass. The issue stage marks destinations pending; writeback clears them.
//  Sits between decode/issue (reads, issue) and writeback (writes) of the pipelined core.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W (localparam)
//  NUM_RD    2   number of read ports (>=1)
//  ZERO_REG  1   1: reg 0 reads 0, ignores writes, never pending
//  BYPASS    1   1: same-cycle write data forwarded to matching read ports
// PORTS
//  clk       in   1               clock, all state on rising edge
//  reset     in   1               synchronous, active-high
//  wr_en     in   2               write enable per write port (port 1 = higher priority)
//  wr_addr   in   2*ADDR_W        write addresses, port p at [p*ADDR_W +: ADDR_W]
//  wr_data   in   2*DATA_W        write data, port p at [p*DATA_W +: DATA_W]
//  rd_addr   in   NUM_RD*ADDR_W   read addresses, packed as above
//  rd_data   out  NUM_RD*DATA_W   read data, combinational
//  rd_ready  out  NUM_RD          1 = rd_data valid (operand not pending, or bypassed)
//  iss_en    in   1               issue request: mark iss_addr pending
//  iss_addr  in   ADDR_W          destination being issued
//  iss_stall out  1               combinational: iss_en & pending[iss_addr] (WAW); issue not accepted
//  busy_cnt  out  ADDR_W+1        number of registers currently pending
// BEHAVIOUR
//  - Reset: every register <= 0, all pending bits <= 0, busy_cnt <= 0. Writes/issues presented
//    in a reset cycle are dropped. rd_data reads 0, rd_ready all 1 from the cycle after reset.
//  - Write: wr_en[p] stores wr_data[p] at wr_addr[p] on the edge (1-cycle write latency).
//    Both ports same address: port 1 data stored, port 0 discarded.
//  - Read: rd_data[i] = array[rd_addr[i]], zero latency. ZERO_REG=1 and addr 0 -> 0.
//    BYPASS=1: if a write this cycle targets rd_addr[i] (addr !=0 when ZERO_REG), rd_data[i]
//    = that write's data (port 1 priority) and rd_ready[i]=1.
//    rd_ready[i] = ~pending[rd_addr[i]] otherwise (BYPASS=0: no forwarding, pending only).
//  - Issue accepted iff iss_en & ~iss_stall (& ~(ZERO_REG & iss_addr==0)): pending[iss_addr] <= 1.
//    iss_stall uses registered pending only; a write clearing the bit in the same cycle does
//    not remove the stall (retry next cycle).
//  - Clear: each write (either port) clears pending[wr_addr[p]] on the edge.
//    Issue and write to same address in one cycle: set wins, bit stays 1, data still written.
//  - busy_cnt next = busy_cnt + (issue accepted) - (#distinct pending bits cleared and not
//    re-set this cycle); same-address dual write clears once. Never exceeds DEPTH-ZERO_REG,
//    never underflows; must equal popcount(pending) at all times.
//  - Writes to a non-pending register are legal (update data, no count change).
//  - Reset asserted mid-operation overrides all same-cycle activity.
// STRUCTURE
//  - regbank_pkg: localparam helpers (DEPTH), packed-port slice functions, pending-vector type.
//  - Sub-module regbank_scoreboard: pending bit vector, iss_stall, busy_cnt; data array,
//    write-priority and read/bypass muxes stay in regbank_sb.
//  - Read ports generated with a for-generate over NUM_RD; no reset-dependent read logic.
// TESTING
//  1 reset, then write port0 r5=0xDEADBEEF; next cycle rd_addr0=5 -> 0xDEADBEEF, rd_ready0=1.
//  2 both ports write r7 (p0=0x11, p1=0x22) -> r7 reads 0x22; BYPASS=1 same-cycle read of r7 -> 0x22.
//  3 ZERO_REG=1: write r0=0xFFFF, issue r0 -> r0 reads 0, busy_cnt stays 0, rd_ready=1.
//  4 issue r3 -> busy_cnt=1, read r3 rd_ready=0; issue r3 again -> iss_stall=1, busy_cnt=1;
//    write r3=0xA5 -> rd_ready=1 (same cycle if BYPASS=1), next cycle busy_cnt=0.
//  5 issue r9 and write r9=0x1 same cycle -> r9 holds 0x1, pending[r9]=1, busy_cnt=1.
//  6 issue r1,r2,r4 then assert reset mid-stream with a write/issue -> all regs 0, busy_cnt=0.
//  Scoreboard assertion every cycle: busy_cnt == popcount(pending).

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared helpers for the register bank slice.
//   depth_of : number of registers addressed by an ADDR_W-bit address
//   cnt_w    : width of a counter that can hold 0..DEPTH inclusive
package regbank_pkg;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned addr_w);
    return addr_w + 32'd1;
  endfunction

endpackage

// File: rtl/regbank_scoreboard.sv
// Pending-bit scoreboard for the register bank.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   wr_en[1:0]         writeback enables (each clears pending[wr_addr[p]])
//   wr_addr            packed writeback addresses, port p at [p*ADDR_W +: ADDR_W]
//   iss_en, iss_addr   issue request marking iss_addr pending
//   pending            registered pending vector, one bit per register
//   iss_stall          iss_en & pending[iss_addr] (WAW hazard, issue refused)
//   busy_cnt           number of pending registers
module regbank_scoreboard
  import regbank_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned DEPTH   = depth_of(ADDR_W),
  localparam int unsigned CNT_W   = cnt_w(ADDR_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          wr_en,
  input  logic [2*ADDR_W-1:0] wr_addr,
  input  logic                iss_en,
  input  logic [ADDR_W-1:0]   iss_addr,
  output logic [DEPTH-1:0]    pending,
  output logic                iss_stall,
  output logic [CNT_W-1:0]    busy_cnt
);

  logic [ADDR_W-1:0] wa0, wa1;
  logic [DEPTH-1:0]  set_vec, clr_vec;
  logic              iss_ok, clr0, clr1;
  logic [1:0]        n_clr;

  assign wa0 = wr_addr[0 +: ADDR_W];
  assign wa1 = wr_addr[ADDR_W +: ADDR_W];

  always_comb begin
    iss_stall = iss_en & pending[iss_addr];
    iss_ok    = iss_en & ~pending[iss_addr] &
                ~((ZERO_REG != 0) && (iss_addr == '0));
    set_vec = '0;
    clr_vec = '0;
    if (iss_ok)   set_vec[iss_addr] = 1'b1;
    if (wr_en[0]) clr_vec[wa0]      = 1'b1;
    if (wr_en[1]) clr_vec[wa1]      = 1'b1;
    // An accepted issue always targets a non-pending bit, so no cleared bit
    // can also be re-set this cycle; only a dual write to one address needs
    // de-duplicating.
    clr0  = wr_en[0] & pending[wa0];
    clr1  = wr_en[1] & pending[wa1] & ~(wr_en[0] & (wa0 == wa1));
    n_clr = {1'b0, clr0} + {1'b0, clr1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      busy_cnt <= '0;
    end else begin
      pending  <= (pending & ~clr_vec) | set_vec;
      busy_cnt <= busy_cnt + CNT_W'(iss_ok) - CNT_W'(n_clr);
    end
  end

endmodule

// File: rtl/regbank_sb.sv
// Multi-port register bank with integrated issue/writeback scoreboard.
// Ports:
//   clk, reset   clock, synchronous active-high reset (clears data and pending)
//   wr_en[1:0]   write enables; port 1 wins on an address collision
//   wr_addr      packed write addresses, port p at [p*ADDR_W +: ADDR_W]
//   wr_data      packed write data,      port p at [p*DATA_W +: DATA_W]
//   rd_addr      packed read addresses (NUM_RD ports)
//   rd_data      packed combinational read data
//   rd_ready     per read port: operand not pending, or forwarded this cycle
//   iss_en/addr  issue request marking a destination pending
//   iss_stall    issue refused because the destination is already pending
//   busy_cnt     number of pending registers
module regbank_sb
  import regbank_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               wr_en,
  input  logic [2*ADDR_W-1:0]      wr_addr,
  input  logic [2*DATA_W-1:0]      wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_stall,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [ADDR_W-1:0] wa0, wa1;
  logic [DATA_W-1:0] wd0, wd1;
  logic              wr_go0, wr_go1;

  assign wa0 = wr_addr[0 +: ADDR_W];
  assign wa1 = wr_addr[ADDR_W +: ADDR_W];
  assign wd0 = wr_data[0 +: DATA_W];
  assign wd1 = wr_data[DATA_W +: DATA_W];

  // Port 0 is suppressed on a collision so the array sees a single writer.
  always_comb begin
    wr_go0 = wr_en[0] & ~(wr_en[1] & (wa0 == wa1));
    wr_go1 = wr_en[1];
    if ((ZERO_REG != 0) && (wa0 == '0)) wr_go0 = 1'b0;
    if ((ZERO_REG != 0) && (wa1 == '0)) wr_go1 = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      if (wr_go0) mem[wa0] <= wd0;
      if (wr_go1) mem[wa1] <= wd1;
    end
  end

  regbank_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .pending   (pending),
    .iss_stall (iss_stall),
    .busy_cnt  (busy_cnt)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] d;
    logic              r;
    logic              zero_hit;

    assign ra       = rd_addr[i*ADDR_W +: ADDR_W];
    assign zero_hit = (ZERO_REG != 0) && (ra == '0);

    // Port 1 forwarding is evaluated last so it overrides port 0.
    always_comb begin
      d = mem[ra];
      r = ~pending[ra];
      if (BYPASS != 0) begin
        if (wr_en[0] && (wa0 == ra)) begin
          d = wd0;
          r = 1'b1;
        end
        if (wr_en[1] && (wa1 == ra)) begin
          d = wd1;
          r = 1'b1;
        end
      end
      if (zero_hit) begin
        d = '0;
        r = 1'b1;
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = d;
    assign rd_ready[i]                 = r;
  end

endmodule

// File: tb/tb_regbank_sb.sv
module tb_regbank_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_ready;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        iss_stall;
  logic [5:0]  busy_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_mem  [32];
  bit          m_pend [32];

  always #5 clk = ~clk;

  regbank_sb #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .NUM_RD   (2),
    .ZERO_REG (1),
    .BYPASS   (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .iss_stall (iss_stall),
    .busy_cnt  (busy_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic setin(input logic r, input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic ie, input logic [4:0] ia, input logic [4:0] r0, input logic [4:0] r1);
    reset    = r;
    wr_en    = {w1, w0};
    wr_addr  = {a1, a0};
    wr_data  = {d1, d0};
    iss_en   = ie;
    iss_addr = ia;
    rd_addr  = {r1, r0};
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
    setin(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, r0, r1);
  endtask

  // Architectural view of a read: r0 is zero, same-cycle writes forward
  // (port 1 first), otherwise stored value and not-pending.
  task automatic exp_read(input logic [4:0] ra, output logic [31:0] d, output logic rdy);
    if (ra == 5'd0) begin
      d = '0; rdy = 1'b1;
    end else if (wr_en[1] && wr_addr[9:5] == ra) begin
      d = wr_data[63:32]; rdy = 1'b1;
    end else if (wr_en[0] && wr_addr[4:0] == ra) begin
      d = wr_data[31:0]; rdy = 1'b1;
    end else begin
      d = m_mem[ra]; rdy = !m_pend[ra];
    end
  endtask

  function automatic int m_busy();
    int c = 0;
    for (int k = 0; k < 32; k++) c += int'(m_pend[k]);
    return c;
  endfunction

  // Wait for the settled mid-cycle point and compare every output with the model.
  task automatic settle_check();
    logic [31:0] d;
    logic        rdy;
    @(negedge clk);
    exp_read(rd_addr[4:0], d, rdy);
    chk("rd_data0", {32'd0, rd_data[31:0]}, {32'd0, d});
    chk("rd_ready0", {63'd0, rd_ready[0]}, {63'd0, rdy});
    exp_read(rd_addr[9:5], d, rdy);
    chk("rd_data1", {32'd0, rd_data[63:32]}, {32'd0, d});
    chk("rd_ready1", {63'd0, rd_ready[1]}, {63'd0, rdy});
    chk("iss_stall", {63'd0, iss_stall}, {63'd0, iss_en && m_pend[iss_addr]});
    chk("busy_cnt", {58'd0, busy_cnt}, 64'(m_busy()));
  endtask

  // Apply the clock edge to the model using the inputs held across it.
  task automatic tick();
    bit acc;
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < 32; k++) begin
        m_mem[k]  = '0;
        m_pend[k] = 1'b0;
      end
    end else begin
      acc = iss_en && !m_pend[iss_addr] && iss_addr != 5'd0;
      if (wr_en[0] && wr_addr[4:0] != 5'd0) m_mem[wr_addr[4:0]] = wr_data[31:0];
      if (wr_en[1] && wr_addr[9:5] != 5'd0) m_mem[wr_addr[9:5]] = wr_data[63:32];
      if (wr_en[0]) m_pend[wr_addr[4:0]] = 1'b0;
      if (wr_en[1]) m_pend[wr_addr[9:5]] = 1'b0;
      if (acc) m_pend[iss_addr] = 1'b1;
    end
    #1;
  endtask

  function automatic logic [4:0] raddr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    // Power-up reset: DUT state is unknown until the first edge.
    setin(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    // Second reset cycle with activity that must be dropped.
    setin(1'b1, 1'b1, 5'd6, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd5, 5'd6);
    @(negedge clk);
    tick();
    idle(5'd5, 5'd6);
    settle_check();
    chk("reset_rd0", {32'd0, rd_data[31:0]}, 64'd0);
    chk("reset_rdy", {62'd0, rd_ready}, 64'd3);
    chk("reset_busy", {58'd0, busy_cnt}, 64'd0);
    tick();

    // 1: single write then read.
    setin(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd1, 5'd2);
    settle_check(); tick();
    idle(5'd5, 5'd0);
    settle_check();
    chk("t1_rd", {32'd0, rd_data[31:0]}, 64'hDEADBEEF);
    chk("t1_rdy", {63'd0, rd_ready[0]}, 64'd1);
    tick();

    // 2: dual write to r7, port 1 wins, also forwarded same cycle.
    setin(1'b0, 1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd5);
    settle_check();
    chk("t2_bypass", {32'd0, rd_data[31:0]}, 64'h22);
    tick();
    idle(5'd7, 5'd5);
    settle_check();
    chk("t2_rd", {32'd0, rd_data[31:0]}, 64'h22);
    tick();

    // 3: register 0 is hardwired.
    setin(1'b0, 1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);
    settle_check();
    chk("t3_rd_same", {32'd0, rd_data[31:0]}, 64'd0);
    tick();
    idle(5'd0, 5'd0);
    settle_check();
    chk("t3_rd", {32'd0, rd_data[31:0]}, 64'd0);
    chk("t3_rdy", {63'd0, rd_ready[0]}, 64'd1);
    chk("t3_busy", {58'd0, busy_cnt}, 64'd0);
    tick();

    // 4: issue, WAW stall, writeback release.
    setin(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd0);
    settle_check(); tick();
    setin(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd0);
    settle_check();
    chk("t4_busy1", {58'd0, busy_cnt}, 64'd1);
    chk("t4_notready", {63'd0, rd_ready[0]}, 64'd0);
    chk("t4_stall", {63'd0, iss_stall}, 64'd1);
    tick();
    setin(1'b0, 1'b1, 5'd3, 32'hA5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0);
    settle_check();
    chk("t4_fwd_rdy", {63'd0, rd_ready[0]}, 64'd1);
    chk("t4_fwd_data", {32'd0, rd_data[31:0]}, 64'hA5);
    chk("t4_busy_still", {58'd0, busy_cnt}, 64'd1);
    tick();
    idle(5'd3, 5'd0);
    settle_check();
    chk("t4_busy0", {58'd0, busy_cnt}, 64'd0);
    tick();

    // 5: issue and write to r9 in one cycle: set wins, data written.
    setin(1'b0, 1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
    settle_check(); tick();
    idle(5'd9, 5'd0);
    settle_check();
    chk("t5_data", {32'd0, rd_data[31:0]}, 64'h1);
    chk("t5_pending", {63'd0, rd_ready[0]}, 64'd0);
    chk("t5_busy", {58'd0, busy_cnt}, 64'd1);
    tick();

    // 6: issue r1, r2, r4, then reset with concurrent write/issue.
    for (int k = 0; k < 3; k++) begin
      setin(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, (k == 2) ? 5'd4 : 5'(k + 1), 5'd1, 5'd2);
      settle_check(); tick();
    end
    idle(5'd1, 5'd4);
    settle_check();
    chk("t6_busy4", {58'd0, busy_cnt}, 64'd4);
    setin(1'b1, 1'b1, 5'd1, 32'h55, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd1, 5'd9);
    @(negedge clk);
    tick();
    idle(5'd1, 5'd9);
    settle_check();
    chk("t6_rd1", {32'd0, rd_data[31:0]}, 64'd0);
    chk("t6_rd9", {32'd0, rd_data[63:32]}, 64'd0);
    chk("t6_rdy", {62'd0, rd_ready}, 64'd3);
    chk("t6_busy", {58'd0, busy_cnt}, 64'd0);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic rs;
      rs = ($urandom_range(0, 99) == 0);
      setin(rs, ($urandom_range(0, 9) < 4), raddr(), $urandom(),
            ($urandom_range(0, 9) < 4), raddr(), $urandom(),
            ($urandom_range(0, 1) == 1), raddr(), raddr(), raddr());
      settle_check();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
